spi_slave_if: RTL and testbench
===============================

// Module: spi_slave_if
// PURPOSE
//   Serial front end for the single-port RAM: an SPI slave, mode 0, MSB first, clocked by sclk.
//   Shifts 10-bit command frames in from mosi and presents each as rx_data/rx_valid to the RAM.
//   Captures the RAM read result (tx_data/tx_valid) and shifts it out on miso.
//   Frame bits [9:8] select the command: 00 write addr, 01 write data, 10 read addr, 11 read data.
// PARAMETERS
//   FRAME_W  10  bits per command frame (rx_data width)
//   DATA_W    8  bits returned by RAM per read (tx_data width)
// PORTS
//   sclk      in   1        clock: one clock; reset is synchronous and active-high
//   rst       in   1        reset (synchronous, active-high)
//   ss_n      in   1        slave select, active low; frame framing
//   mosi      in   1        serial data in, sampled on posedge sclk
//   miso      out  1        serial data out, registered
//   rx_data   out  FRAME_W  assembled frame to RAM din
//   rx_valid  out  1        one-cycle strobe, rx_data valid
//   tx_data   in   DATA_W   RAM read data (RAM dout)
//   tx_valid  in   1        RAM read data valid strobe
// BEHAVIOUR
//   Reset: state=IDLE; miso=0; rx_data=0; rx_valid=0; bit counter=0; rd_addr_seen=0; tx shift reg=0.
//   States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA (registered, one transition per posedge).
//   IDLE: ss_n=0 -> CHK_CMD; else stay.
//   CHK_CMD: mosi is frame bit 9, stored into rx_data[9].
//     mosi=0 -> WRITE.
//     mosi=1 & rd_addr_seen=0 -> READ_ADD.
//     mosi=1 & rd_addr_seen=1 -> READ_DATA.
//   WRITE / READ_ADD / READ_DATA: shift frame bits 8..0 MSB-first, one per cycle; counter 0..8.
//     The edge capturing bit 0 updates rx_data and sets rx_valid=1 for exactly one cycle.
//     rx_valid is 0 in every other cycle. rx_data holds its value until the next completed frame.
//   Frame-level decode uses only bit 9, so bit 8 is forwarded unchecked; the RAM decodes [9:8].
//   READ_ADD on frame completion: rd_addr_seen<=1; wait for ss_n=1.
//   WRITE on frame completion: wait for ss_n=1.
//   READ_DATA after frame completion: wait for tx_valid.
//     The edge sampling tx_valid=1 loads tx_data into the shift reg.
//     miso = tx_data[7] in the following cycle, then bits 6..0 on successive cycles (8 cycles).
//     The RAM registers rx_valid, so tx_valid is expected 1 cycle after rx_valid.
//     miso returns to 0 after bit 0; rd_addr_seen<=0; then wait for ss_n=1.
//   miso=0 whenever no read data is being shifted. tx_valid outside READ_DATA wait is ignored.
//   ss_n=1 in any non-IDLE state -> IDLE next edge. Abort effects:
//     counter cleared; partial frame discarded; no rx_valid; miso<=0; pending read output dropped.
//     rd_addr_seen unchanged on abort.
//   ss_n must return high between frames; extra bits after completion are ignored.
//   rst=1 at any edge overrides all, including mid-frame and mid-shift-out.
// TESTING
//   1 Write addr: ss_n=0, frame 10'b00_0000_0101 -> rx_valid 1 cycle after 10th bit, rx_data=0x005.
//   2 Write data: frame 10'b01_1010_0101 -> rx_data=0x1A5, single rx_valid pulse; miso stays 0.
//   3 Read addr then read data (addr 0x05, RAM holds 0xA5):
//     frame 0x205 enters READ_ADD.
//     Next frame 0x300 enters READ_DATA; tx_valid returns 0xA5.
//     miso shows 1,0,1,0,0,1,0,1; rd_addr_seen clears.
//   4 Abort: ss_n=1 after 4 frame bits -> state IDLE next edge, no rx_valid, rx_data unchanged;
//     the following full frame decodes correctly.
//   5 Reset mid-readout: rst=1 during miso bit 3 -> next cycle miso=0, IDLE, rd_addr_seen=0.
//   6 Second read without new read addr after readout -> frame with bit9=1 routes to READ_ADD.

Source files
------------

// File: rtl/spi_slave_if_if.sv
// Bus bundle between the SPI slave front end and its RAM-side/serial-side peers.
interface spi_slave_if_if #(
    parameter int FRAME_W = 10,
    parameter int DATA_W  = 8
);
    logic               ss_n;
    logic               mosi;
    logic               miso;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;

    modport slave (
        input  ss_n, mosi, tx_data, tx_valid,
        output miso, rx_data, rx_valid
    );

    modport master (
        output ss_n, mosi, tx_data, tx_valid,
        input  miso, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave: assembles 10-bit command frames for the RAM and shifts read data back out.
// state     | meaning
// IDLE      | waiting for ss_n low
// CHK_CMD   | sampling frame bit 9 to pick the path
// WRITE     | shifting a write addr/data frame
// READ_ADD  | shifting a read-address frame
// READ_DATA | shifting a read-data frame, then returning tx_data on miso
module spi_slave_if #(
    parameter int FRAME_W = 10,
    parameter int DATA_W  = 8
) (
    input  logic             sclk,
    input  logic             rst,
    spi_slave_if_if.slave    bus
);
    localparam int CNT_W    = $clog2(FRAME_W - 1);
    localparam int TX_CNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_W-2:0]    rx_shift;
    logic                  frame_done;
    logic                  rd_addr_seen;
    logic [DATA_W-1:0]     tx_shift;
    logic [TX_CNT_W-1:0]   tx_cnt;
    logic                  tx_busy;
    logic                  tx_done;

    always_ff @(posedge sclk) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            frame_done   <= 1'b0;
            rd_addr_seen <= 1'b0;
            tx_shift     <= '0;
            tx_cnt       <= '0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            bus.miso     <= 1'b0;
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            // Deselect aborts everything except the remembered read address.
            if (state != IDLE && bus.ss_n) begin
                state      <= IDLE;
                bit_cnt    <= '0;
                frame_done <= 1'b0;
                tx_busy    <= 1'b0;
                tx_done    <= 1'b0;
                tx_shift   <= '0;
                bus.miso   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!bus.ss_n)
                            state <= CHK_CMD;
                    end
                    CHK_CMD: begin
                        rx_shift   <= {{(FRAME_W-2){1'b0}}, bus.mosi};
                        bit_cnt    <= CNT_W'(FRAME_W - 2);
                        frame_done <= 1'b0;
                        if (!bus.mosi)
                            state <= WRITE;
                        else if (!rd_addr_seen)
                            state <= READ_ADD;
                        else
                            state <= READ_DATA;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (!frame_done) begin
                            if (bit_cnt == '0) begin
                                bus.rx_data  <= {rx_shift, bus.mosi};
                                bus.rx_valid <= 1'b1;
                                frame_done   <= 1'b1;
                                if (state == READ_ADD)
                                    rd_addr_seen <= 1'b1;
                            end else begin
                                rx_shift <= {rx_shift[FRAME_W-3:0], bus.mosi};
                                bit_cnt  <= bit_cnt - 1'b1;
                            end
                        end else if (state == READ_DATA) begin
                            if (tx_busy) begin
                                if (tx_cnt != '0) begin
                                    bus.miso <= tx_shift[DATA_W-1];
                                    tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                                    tx_cnt   <= tx_cnt - 1'b1;
                                end else begin
                                    bus.miso     <= 1'b0;
                                    tx_busy      <= 1'b0;
                                    tx_done      <= 1'b1;
                                    rd_addr_seen <= 1'b0;
                                end
                            end else if (!tx_done && bus.tx_valid) begin
                                bus.miso <= bus.tx_data[DATA_W-1];
                                tx_shift <= {bus.tx_data[DATA_W-2:0], 1'b0};
                                tx_cnt   <= TX_CNT_W'(DATA_W - 1);
                                tx_busy  <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: frame capture, read return, abort and reset behaviour.
module tb_spi_slave_if;
    logic sclk = 1'b0;
    logic rst  = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int         early;
    logic       v;
    logic [9:0] d;
    logic [7:0] seen;
    logic       tail;

    always #5 sclk = ~sclk;

    spi_slave_if_if bus ();
    spi_slave_if dut (.sclk(sclk), .rst(rst), .bus(bus));

    // Drives a full frame; leaves ss_n low, returns at the negedge after the bit-0 edge.
    task automatic run_frame(input logic [9:0] f, output int n_early, output logic v_end,
                             output logic [9:0] d_end);
        n_early  = 0;
        bus.ss_n = 1'b0;
        bus.mosi = 1'b0;
        @(negedge sclk);
        for (int i = 9; i >= 0; i--) begin
            bus.mosi = f[i];
            @(negedge sclk);
            if (i > 0 && bus.rx_valid === 1'b1) n_early++;
        end
        v_end = bus.rx_valid;
        d_end = bus.rx_data;
    endtask

    // RAM model: tx_valid one cycle after rx_valid, then capture 8 miso bits and the one after.
    task automatic ram_reply(input logic [7:0] data, output logic [7:0] bits, output logic after);
        @(negedge sclk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = data;
        @(negedge sclk);
        bus.tx_valid = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (k < 7) @(negedge sclk);
            bits[k] = bus.miso;
        end
        @(negedge sclk);
        after = bus.miso;
    endtask

    task automatic end_frame();
        bus.ss_n = 1'b1;
        bus.mosi = 1'b0;
        @(negedge sclk);
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.ss_n = 1'b1; bus.mosi = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;
        repeat (3) @(negedge sclk);
        rst = 1'b0;
        @(negedge sclk);
        checks++; if (bus.miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", bus.miso); end
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", bus.rx_valid); end
        checks++; if (bus.rx_data !== 10'h000) begin errors++; $display("FAIL reset_rx_data: got %h expected 000", bus.rx_data); end
    endtask

    task automatic test_write_addr();
        run_frame(10'h005, early, v, d);
        checks++; if (early !== 0) begin errors++; $display("FAIL wa_early_valid: got %0d expected 0", early); end
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL wa_rx_valid: got %b expected 1", v); end
        checks++; if (d !== 10'h005) begin errors++; $display("FAIL wa_rx_data: got %h expected 005", d); end
        @(negedge sclk);
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL wa_pulse_len: got %b expected 0", bus.rx_valid); end
        checks++; if (bus.rx_data !== 10'h005) begin errors++; $display("FAIL wa_hold: got %h expected 005", bus.rx_data); end
        end_frame();
    endtask

    task automatic test_write_data();
        run_frame(10'h1A5, early, v, d);
        checks++; if (v !== 1'b1 || early !== 0) begin errors++; $display("FAIL wd_rx_valid: got %b/%0d expected 1/0", v, early); end
        checks++; if (d !== 10'h1A5) begin errors++; $display("FAIL wd_rx_data: got %h expected 1a5", d); end
        bus.mosi = 1'b1;
        ram_reply(8'hFF, seen, tail);
        checks++; if (seen !== 8'h00 || tail !== 1'b0) begin errors++; $display("FAIL wd_miso_quiet: got %h/%b expected 00/0", seen, tail); end
        checks++; if (bus.rx_valid !== 1'b0 || bus.rx_data !== 10'h1A5) begin errors++; $display("FAIL wd_extra_bits: got %b/%h expected 0/1a5", bus.rx_valid, bus.rx_data); end
        end_frame();
    endtask

    task automatic test_read();
        run_frame(10'h205, early, v, d);
        checks++; if (v !== 1'b1 || d !== 10'h205) begin errors++; $display("FAIL rd_addr_frame: got %b/%h expected 1/205", v, d); end
        ram_reply(8'hA5, seen, tail);
        checks++; if (seen !== 8'h00) begin errors++; $display("FAIL rd_addr_no_miso: got %h expected 00", seen); end
        end_frame();
        run_frame(10'h300, early, v, d);
        checks++; if (v !== 1'b1 || d !== 10'h300) begin errors++; $display("FAIL rd_data_frame: got %b/%h expected 1/300", v, d); end
        ram_reply(8'hA5, seen, tail);
        checks++; if (seen !== 8'hA5) begin errors++; $display("FAIL rd_miso_bits: got %h expected a5", seen); end
        checks++; if (tail !== 1'b0) begin errors++; $display("FAIL rd_miso_tail: got %b expected 0", tail); end
        end_frame();
    endtask

    task automatic test_reread_needs_addr();
        run_frame(10'h300, early, v, d);
        checks++; if (v !== 1'b1 || d !== 10'h300) begin errors++; $display("FAIL rr_frame: got %b/%h expected 1/300", v, d); end
        ram_reply(8'hFF, seen, tail);
        checks++; if (seen !== 8'h00 || tail !== 1'b0) begin errors++; $display("FAIL rr_routes_read_add: got %h/%b expected 00/0", seen, tail); end
        end_frame();
    endtask

    task automatic test_abort();
        logic [9:0] f = 10'h0F0;
        int         pulses = 0;
        bus.ss_n = 1'b0;
        @(negedge sclk);
        for (int i = 9; i >= 6; i--) begin
            bus.mosi = f[i];
            @(negedge sclk);
            if (bus.rx_valid === 1'b1) pulses++;
        end
        end_frame();
        if (bus.rx_valid === 1'b1) pulses++;
        checks++; if (pulses !== 0) begin errors++; $display("FAIL ab_no_valid: got %0d expected 0", pulses); end
        checks++; if (bus.rx_data !== 10'h300) begin errors++; $display("FAIL ab_rx_data_kept: got %h expected 300", bus.rx_data); end
        run_frame(10'h0C3, early, v, d);
        checks++; if (v !== 1'b1 || d !== 10'h0C3 || early !== 0) begin errors++; $display("FAIL ab_next_frame: got %b/%h/%0d expected 1/0c3/0", v, d, early); end
        end_frame();
    endtask

    task automatic test_reset_mid_readout();
        logic [7:0] part = '0;
        run_frame(10'h300, early, v, d);
        checks++; if (v !== 1'b1 || d !== 10'h300) begin errors++; $display("FAIL rm_frame: got %b/%h expected 1/300", v, d); end
        @(negedge sclk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hA5;
        @(negedge sclk);
        bus.tx_valid = 1'b0;
        for (int k = 7; k >= 3; k--) begin
            if (k < 7) @(negedge sclk);
            part[k] = bus.miso;
        end
        checks++; if (part[7:3] !== 5'b10100) begin errors++; $display("FAIL rm_partial_bits: got %b expected 10100", part[7:3]); end
        rst = 1'b1;
        bus.ss_n = 1'b1;
        @(negedge sclk);
        checks++; if (bus.miso !== 1'b0) begin errors++; $display("FAIL rm_miso: got %b expected 0", bus.miso); end
        checks++; if (bus.rx_valid !== 1'b0 || bus.rx_data !== 10'h000) begin errors++; $display("FAIL rm_rx_cleared: got %b/%h expected 0/000", bus.rx_valid, bus.rx_data); end
        rst = 1'b0;
        @(negedge sclk);
        run_frame(10'h2AA, early, v, d);
        checks++; if (v !== 1'b1 || d !== 10'h2AA) begin errors++; $display("FAIL rm_next_frame: got %b/%h expected 1/2aa", v, d); end
        ram_reply(8'hFF, seen, tail);
        checks++; if (seen !== 8'h00) begin errors++; $display("FAIL rm_addr_seen_cleared: got %h expected 00", seen); end
        end_frame();
    endtask

    task automatic test_back_to_back();
        run_frame(10'h3C3, early, v, d);
        checks++; if (v !== 1'b1 || d !== 10'h3C3) begin errors++; $display("FAIL bb_frame1: got %b/%h expected 1/3c3", v, d); end
        ram_reply(8'h3C, seen, tail);
        checks++; if (seen !== 8'h3C || tail !== 1'b0) begin errors++; $display("FAIL bb_miso1: got %h/%b expected 3c/0", seen, tail); end
        end_frame();
        run_frame(10'h3C3, early, v, d);
        checks++; if (v !== 1'b1 || d !== 10'h3C3) begin errors++; $display("FAIL bb_frame2: got %b/%h expected 1/3c3", v, d); end
        ram_reply(8'h3C, seen, tail);
        checks++; if (seen !== 8'h00) begin errors++; $display("FAIL bb_miso2: got %h expected 00", seen); end
        end_frame();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_addr();
        test_write_data();
        test_read();
        test_reread_needs_addr();
        test_abort();
        test_reset_mid_readout();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
